// File: rtl/alu_serial_pkg.sv
// -----------------------------------------------------------------------------
// alu_serial_pkg
// Shared encodings for the bit-serial ALU:
//   OP_AND/OP_OR/OP_XOR/OP_ADD : 2-bit opcode values, which are also the
//                                select values of the output 4:1 mux
//   ST_IDLE/ST_RUN/ST_DONE     : FSM state encodings
//   maj3()                     : full-adder carry (majority of three bits)
// -----------------------------------------------------------------------------
package alu_serial_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/mux4_1.sv
// -----------------------------------------------------------------------------
// mux4_1
// 1-bit 4:1 multiplexer.
//   a, b, c, d : data inputs, selected by S = 00, 01, 10, 11
//   S          : 2-bit select
//   out        : selected bit
// -----------------------------------------------------------------------------
module mux4_1 (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic [1:0] S,
    output logic       out
);

    always_comb begin
        case (S)
            2'b00:   out = a;
            2'b01:   out = b;
            2'b10:   out = c;
            default: out = d;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// -----------------------------------------------------------------------------
// alu_serial
// Bit-serial WIDTH-bit ALU. Operands are consumed LSB-first, one bit per clock,
// through 1-bit AND/OR/XOR/full-adder slices; mux4_1 picks the slice given by
// the latched opcode and its output is shifted into the result MSB.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only in IDLE
//   op         : 00 AND, 01 OR, 10 XOR, 11 ADD
//   a, b       : operands, latched at accept
//   sub        : subtract select for ADD (only with ALU_SERIAL_SUB_EN)
//   busy       : high while bits are being processed
//   done       : one-cycle pulse, result/carry/zero valid
//   result     : final result (held until next accept)
//   carry      : ADD carry-out (NOT borrow when subtracting), 0 for logic ops
//   zero       : result == 0
//
// Build option: define ALU_SERIAL_SUB_EN to add the sub port and A-B support.
// -----------------------------------------------------------------------------
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ALU_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sa, sb;
    logic [1:0]       sop;
    logic             cf;
    logic [CW-1:0]    cnt;

    logic             x, y, bit_out, cf_nxt, sub_acc;
    logic [WIDTH-1:0] res_nxt;

    assign x = sa[0];
    assign y = sb[0];

    mux4_1 u_mux (
        .a   (x & y),
        .b   (x | y),
        .c   (x ^ y),
        .d   (x ^ y ^ cf),
        .S   (sop),
        .out (bit_out)
    );

    assign res_nxt = {bit_out, result[WIDTH-1:1]};
    // Carry chain only runs for ADD; logic ops keep cf at its cleared value.
    assign cf_nxt  = (sop == OP_ADD) ? maj3(x, y, cf) : 1'b0;

    // Subtract = A + ~B + 1: invert B and preload the carry at accept.
`ifdef ALU_SERIAL_SUB_EN
    assign sub_acc = sub && (op == OP_ADD);
`else
    assign sub_acc = 1'b0;
`endif

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            sa     <= '0;
            sb     <= '0;
            sop    <= OP_AND;
            cf     <= 1'b0;
            cnt    <= '0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_RUN;
                        sa     <= a;
                        sb     <= sub_acc ? ~b : b;
                        sop    <= op;
                        cf     <= sub_acc;
                        cnt    <= '0;
                        result <= '0;
                        carry  <= 1'b0;
                        zero   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    result <= res_nxt;
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    cf     <= cf_nxt;
                    cnt    <= cnt + CW'(1);
                    // Flags are captured from the final bit's next-state values.
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                        carry <= cf_nxt;
                        zero  <= (res_nxt == '0);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
module tb_alu_serial;
    import alu_serial_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0;
    logic         sub = 1'b0;
    logic         busy, done, carry, zero;
    logic [W-1:0] result;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    alu_serial #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
`ifdef ALU_SERIAL_SUB_EN
        .sub    (sub),
`endif
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse consumes one expected response.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_result", 32'(result), 32'(e.res));
                check("sb_carry",  32'(carry),  32'(e.c));
                check("sb_zero",   32'(zero),   32'(e.z));
            end
        end
    end

    // Issue one operation, push its expectation, and verify handshake timing.
    task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [1:0] top, input logic tsub,
                         input logic [W-1:0] er, input logic ec, input logic ez);
        exp_t e;
        int   edges, busy_cnt;
        @(negedge clk);
        a = ta; b = tb_; op = top; sub = tsub; start = 1'b1;
        e.res = er; e.c = ec; e.z = ez;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        // Operands only matter at the accept edge.
        a = ~ta; b = ~tb_; op = ~top; sub = ~tsub;
        edges = 0; busy_cnt = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            edges++;
        end
        check({name, "_latency"}, 32'(edges), 32'(W));
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int done_cnt;
        exp_t e;

        // Reset state
        #12;
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry",  32'(carry),  32'd0);
        check("rst_zero",   32'(zero),   32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Main function
        do_op("add",     8'h5A, 8'h3C, OP_ADD, 1'b0, 8'h96, 1'b0, 1'b0);
        do_op("add_ovf", 8'hFF, 8'h01, OP_ADD, 1'b0, 8'h00, 1'b1, 1'b1);
        do_op("and",     8'hF0, 8'h3C, OP_AND, 1'b0, 8'h30, 1'b0, 1'b0);
        do_op("or",      8'hF0, 8'h3C, OP_OR,  1'b0, 8'hFC, 1'b0, 1'b0);
        do_op("xor",     8'hF0, 8'h3C, OP_XOR, 1'b0, 8'hCC, 1'b0, 1'b0);
        do_op("xor_z",   8'hA5, 8'hA5, OP_XOR, 1'b0, 8'h00, 1'b0, 1'b1);
`ifdef ALU_SERIAL_SUB_EN
        do_op("sub_a",   8'h10, 8'h01, OP_ADD, 1'b1, 8'h0F, 1'b1, 1'b0);
        do_op("sub_b",   8'h00, 8'h01, OP_ADD, 1'b1, 8'hFF, 1'b0, 1'b0);
        do_op("sub_c",   8'h33, 8'h33, OP_ADD, 1'b1, 8'h00, 1'b1, 1'b1);
        do_op("sub_ign", 8'hF0, 8'h3C, OP_OR,  1'b1, 8'hFC, 1'b0, 1'b0);
`endif

        // Reset three cycles into RUN aborts without a done pulse
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; op = OP_OR; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #3; rst_n = 1'b0; #1;
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_done",   32'(done),   32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_carry",  32'(carry),  32'd0);
        check("abort_zero",   32'(zero),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        do_op("post_rst", 8'h01, 8'h02, OP_ADD, 1'b0, 8'h03, 1'b0, 1'b0);

        // start held high 12 cycles with changing operands
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = 1'b1; op = OP_ADD; sub = 1'b0;
            if (i == 0) begin
                a = 8'h11; b = 8'h22;
                e.res = 8'h33; e.c = 1'b0; e.z = 1'b0; exp_q.push_back(e);
            end else begin
                a = 8'h40 + 8'(i); b = 8'h05;
                if (i == 10) begin
                    e.res = 8'h4F; e.c = 1'b0; e.z = 1'b0; exp_q.push_back(e);
                end
            end
            @(posedge clk); #1;
            if (done) done_cnt++;
            if (i == 8) check("hs_done_e8", 32'(done), 32'd1);
            if (i == 9) begin
                check("hs_idle_busy", 32'(busy), 32'd0);
                check("hs_hold_result", 32'(result), 32'h33);
            end
            if (i == 10) check("hs_reaccept_busy", 32'(busy), 32'd1);
        end
        @(negedge clk); start = 1'b0;
        check("hs_single_done", 32'(done_cnt), 32'd1);
        begin
            int k = 0;
            while (!done && k < 40) begin
                @(posedge clk); #1;
                k++;
            end
            check("hs_second_done", 32'(done), 32'd1);
        end
        repeat (3) @(posedge clk);
        #1;
        check("hold_result_idle", 32'(result), 32'h4F);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_serial.md
# alu_serial

Bit-serial N-bit ALU datapath built around the existing 1-bit 4:1 multiplexer. Operands are shifted LSB-first through 1-bit AND/OR/XOR/full-adder slices. The mux picks the slice selected by the latched opcode, and its output is shifted into the result register, one bit per clock. It sits between the operand/opcode source and the register write-back, with a start/busy/done handshake.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH ≥ 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 AND, 01 OR, 10 XOR, 11 ADD
- a  in  WIDTH  operand A, latched on accept
- b  in  WIDTH  operand B, latched on accept
- sub  in  1  subtract select for op 11 (present only with ALU_SERIAL_SUB_EN)
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  final result
- carry  out  1  ADD carry-out; 0 for logic ops
- zero  out  1  result == 0

One clock; reset is asynchronous and active-low.

## Operation
- FSM states:
  - IDLE → RUN on start=1.
  - RUN → DONE after WIDTH bit-cycles.
  - DONE → IDLE unconditionally.
- Accept (IDLE, start=1):
  - latch a, b, op into shift registers sa, sb, sop
  - clear carry flop cf (set to 1 for subtract, see Configuration)
  - clear bit counter and result
- RUN, per cycle, on x = sa[0] and y = sb[0]:
  - mux inputs: x&y, x|y, x^y, x^y^cf
  - mux select = sop; mux output shifts into the result MSB: result ← {bit, result[WIDTH-1:1]}
  - sa and sb shift right
  - cf ← majority(x, y, cf) only when sop = 11; otherwise cf stays 0
- Counter is $clog2(WIDTH) bits; RUN exits when counter = WIDTH-1 on that cycle.
- DONE:
  - done = 1
  - carry = cf
  - zero = (result == 0), registered on entry to DONE
- result, carry and zero hold until the next accept. Mid-RUN result contents are partial and not valid.
- start during RUN or DONE is ignored; no queuing.
- Reset, any time: state IDLE; busy, done, result, carry, zero and all internal registers = 0. Reset during RUN aborts the operation with no done pulse.

## Timing
- Accept edge E0: busy = 1 after E0.
- Bits are processed on edges E1..EWIDTH.
- After edge EWIDTH: busy = 0, done = 1, and result/carry/zero are valid.
- After edge EWIDTH+1: done = 0, state IDLE.
- Earliest next accept is edge EWIDTH+2.
- Throughput: one operation per WIDTH+2 cycles.
- Inputs a, b, op and sub only need to be stable at the accept edge.

## Configuration
- ALU_SERIAL_SUB_EN defined:
  - `sub` port exists.
  - With op = 11 and sub = 1 at accept: b is latched inverted and cf is initialised to 1 (two's-complement A−B).
  - carry then reports NOT borrow.
  - sub is ignored for ops 00–10.
- ALU_SERIAL_SUB_EN undefined: no `sub` port; op 11 is always A+B with cf initialised to 0.

## Structure
- Package alu_serial_pkg holds:
  - op encodings OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_ADD = 2'b11
  - FSM state encodings ST_IDLE, ST_RUN, ST_DONE
- Single sub-module: the existing mux4_1, instantiated once. Slice outputs drive a/b/c/d, sop drives S, and out feeds the result shift.
- Slice logic, shift registers, counter and FSM live in alu_serial.

## Test plan
- Reset: assert rst_n = 0 three cycles into RUN → busy = 0, done = 0, result = 0, carry = 0, zero = 0 immediately. No done pulse follows. After release, a new start is accepted normally.
- ADD, WIDTH = 8: 0x5A + 0x3C → done exactly 8 edges after the accept edge, result = 0x96, carry = 0, zero = 0. busy is high for exactly 8 cycles.
- ADD overflow: 0xFF + 0x01 → result = 0x00, carry = 1, zero = 1.
- Logic ops on a = 0xF0, b = 0x3C:
  - AND → 0x30
  - OR → 0xFC
  - XOR → 0xCC
  - carry = 0 for all three
- Handshake: hold start = 1 for 12 cycles with operands changing each cycle → only the first operands are used. One done pulse appears, the next accept occurs in IDLE, and result holds between operations.
- With ALU_SERIAL_SUB_EN, sub = 1:
  - 0x10 − 0x01 → result 0x0F, carry 1
  - 0x00 − 0x01 → result 0xFF, carry 0
  - 0x33 − 0x33 → result 0x00, zero 1
